// File: rtl/cordic_pkg.sv
// Shared constants for the CORDIC datapath blocks.
// Latency: n/a (constants only).
// Backpressure: n/a.
package cordic_pkg;

   // Default datapath width used by the x/y/z update adders.
   localparam int CORDIC_W     = 16;
   // Widest adder the datapath is expected to instantiate.
   localparam int CORDIC_MAX_W = 64;

endpackage : cordic_pkg

// File: rtl/full_adder.sv
// One-bit full-adder cell, the building block of the ripple-carry core.
// Latency: purely combinational.
// Backpressure: none.
// Ports: a, b, cin -> s (sum bit), cout (carry to the next cell).
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   logic w_p;

   // Propagate term is shared by the sum and the carry equations.
   assign w_p  = a ^ b;
   assign s    = w_p ^ cin;
   assign cout = (a & b) | (cin & w_p);

endmodule : full_adder

// File: rtl/cordic_adder.sv
// N-bit ripple-carry adder with carry-in/out and registered result for the CORDIC datapath.
// Latency: 1 cycle from in_valid to out_valid; one operation per cycle, no bubbles.
// Backpressure: none; the consumer must take the result whenever out_valid is high.
// Ports: clk, rst (sync, active-high), in_valid, a, b, cin -> s, cout, out_valid
//        (plus ovf, signed overflow, when CORDIC_ADDER_OVF_EN is defined).
// N is expected to lie in 2..CORDIC_MAX_W.
module cordic_adder
   import cordic_pkg::*;
#(
   parameter int N = CORDIC_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         cin,
   output logic [N-1:0] s,
   output logic         cout,
`ifdef CORDIC_ADDER_OVF_EN
   output logic         ovf,
`endif
   output logic         out_valid
);

   logic [N-1:0] w_sum;
   // w_carry[i] is the carry into cell i; w_carry[N] is the final carry-out.
   logic [N:0]   w_carry;

   logic [N-1:0] r_s;
   logic         r_cout;
   logic         r_vld;

   assign w_carry[0] = cin;

   for (genvar i = 0; i < N; i++) begin : g_fa
      full_adder u_fa (
         .a    (a[i]),
         .b    (b[i]),
         .cin  (w_carry[i]),
         .s    (w_sum[i]),
         .cout (w_carry[i+1])
      );
   end

   // Reset wins over a same-cycle valid, so that operation is dropped.
   // Without a valid input the result holds and only the strobe drops.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_s    <= '0;
         r_cout <= 1'b0;
         r_vld  <= 1'b0;
      end else begin
         r_vld <= in_valid;
         if (in_valid) begin
            r_s    <= w_sum;
            r_cout <= w_carry[N];
         end
      end
   end

`ifdef CORDIC_ADDER_OVF_EN
   logic r_ovf;

   // Signed overflow: carry into the MSB differs from carry out of it.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ovf <= 1'b0;
      end else if (in_valid) begin
         r_ovf <= w_carry[N-1] ^ w_carry[N];
      end
   end

   assign ovf = r_ovf;
`endif

   assign s         = r_s;
   assign cout      = r_cout;
   assign out_valid = r_vld;

endmodule : cordic_adder

// File: tb/tb_cordic_adder.sv
module tb_cordic_adder;

   localparam int N = 16;
   localparam logic [N-1:0] ONES = {N{1'b1}};

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic         cin;
   logic [N-1:0] s;
   logic         cout;
   logic         out_valid;
`ifdef CORDIC_ADDER_OVF_EN
   logic         ovf;
`endif

   int checks = 0;
   int errors = 0;

   // Reference state: what the outputs should show after the latest edge.
   logic [N-1:0] m_s    = '0;
   logic         m_cout = 1'b0;
   logic         m_vld  = 1'b0;
   logic         m_ovf  = 1'b0;

   always #5 clk = ~clk;

   cordic_adder #(.N(N)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .s         (s),
      .cout      (cout),
`ifdef CORDIC_ADDER_OVF_EN
      .ovf       (ovf),
`endif
      .out_valid (out_valid)
   );

   task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle of inputs, clock it, update the reference and compare.
   task automatic step(input logic r, input logic v, input logic [N-1:0] ta,
                       input logic [N-1:0] tb_v, input logic tc, input string tag);
      longint unsigned total;
      longint          sa, sb, ssum;
      @(negedge clk);
      rst      = r;
      in_valid = v;
      a        = ta;
      b        = tb_v;
      cin      = tc;
      @(posedge clk);
      #1;
      if (r) begin
         m_s = '0; m_cout = 1'b0; m_vld = 1'b0; m_ovf = 1'b0;
      end else if (v) begin
         total  = longint'(ta) + longint'(tb_v) + longint'(tc);
         m_s    = N'(total);
         m_cout = total[N];
         // Signed overflow: true signed sum leaves the N-bit signed range.
         sa     = longint'($signed(ta));
         sb     = longint'($signed(tb_v));
         ssum   = sa + sb + longint'(tc);
         m_ovf  = (ssum > (longint'(1) <<< (N-1)) - 1) || (ssum < -(longint'(1) <<< (N-1)));
         m_vld  = 1'b1;
      end else begin
         m_vld = 1'b0;
      end
      check({tag, ".s"},         65'(s),         65'(m_s));
      check({tag, ".cout"},      65'(cout),      65'(m_cout));
      check({tag, ".out_valid"}, 65'(out_valid), 65'(m_vld));
`ifdef CORDIC_ADDER_OVF_EN
      check({tag, ".ovf"},       65'(ovf),       65'(m_ovf));
`endif
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0;

      // Reset held for two cycles while valid random operands are offered.
      step(1'b1, 1'b1, N'($urandom), N'($urandom), 1'($urandom), "reset0");
      step(1'b1, 1'b1, N'($urandom), N'($urandom), 1'($urandom), "reset1");
      check("reset.s_const", 65'(s), 65'(0));

      step(1'b0, 1'b1, N'(0), N'(0), 1'b0, "zero");
      check("zero.valid_const", 65'(out_valid), 65'(1));

      step(1'b0, 1'b1, N'(20), N'(15), 1'b0, "b2b0");
      check("b2b0.s_const", 65'(s), 65'(35));
      step(1'b0, 1'b1, N'(10), N'(15), 1'b1, "b2b1");
      check("b2b1.s_const", 65'(s), 65'(26));

      step(1'b0, 1'b1, ONES, ONES, 1'b1, "ones_ones_1");
      check("ones_ones_1.s_const", 65'(s), 65'(ONES));
      check("ones_ones_1.cout_const", 65'(cout), 65'(1));
      step(1'b0, 1'b1, ONES, N'(0), 1'b1, "wrap");
      check("wrap.s_const", 65'(s), 65'(0));
      check("wrap.cout_const", 65'(cout), 65'(1));

      // Hold: result stays while in_valid is low, strobe drops.
      step(1'b0, 1'b1, N'(7), N'(8), 1'b0, "hold_load");
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b0, N'($urandom), N'($urandom), 1'($urandom), "hold");
         check("hold.s_const", 65'(s), 65'(15));
      end

      // Reset beats a same-cycle valid; nothing emerges afterwards.
      step(1'b1, 1'b1, N'(3), N'(4), 1'b0, "rst_prio");
      check("rst_prio.s_const", 65'(s), 65'(0));
      step(1'b0, 1'b0, N'(0), N'(0), 1'b0, "rst_after");

      step(1'b0, 1'b1, N'(16'h7FFF), N'(1), 1'b0, "pos_ovf");
      check("pos_ovf.s_const", 65'(s), 65'(16'h8000));
      step(1'b0, 1'b1, N'(16'h8000), N'(16'h8000), 1'b0, "neg_ovf");
      check("neg_ovf.cout_const", 65'(cout), 65'(1));

      // Random traffic: mostly valid, some idle cycles, rare resets.
      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
              N'($urandom), N'($urandom), 1'($urandom), "rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_cordic_adder

// File: doc/cordic_adder.md
Name: cordic_adder

Overview:
- Parameterised N-bit binary adder with carry-in and carry-out, used in the CORDIC datapath for the x/y/z update additions.
- Combinational ripple-carry core built from full-adder cells.
- Result, carry and valid are registered, giving a fixed 1-cycle latency with a simple valid strobe.

Parameters:
- N, 16, operand/sum width in bits; legal range 2..64.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  operands a/b/cin valid this cycle
- a  input  N  operand A, unsigned (two's-complement bit pattern allowed)
- b  input  N  operand B
- cin  input  1  carry-in
- s  output  N  registered sum, (a+b+cin) mod 2^N
- cout  output  1  registered carry-out, bit N of a+b+cin
- out_valid  output  1  s/cout updated from a valid input last cycle

Behaviour:
- Reset: on a rising clk edge with rst=1, s=0, cout=0, out_valid=0. rst has priority over in_valid in the same cycle.
- Arithmetic: {cout,s} = a + b + cin, computed at N+1 bits with no truncation of the carry.
- Core: N chained full_adder cells.
  - Cell 0 takes cin.
  - Cell i takes the carry out of cell i-1.
  - The carry out of cell N-1 is cout.
- Latency: exactly 1 cycle. Inputs sampled at edge k with in_valid=1 appear on s/cout after edge k, and out_valid=1 for that one cycle.
- in_valid=0 at an edge:
  - s/cout hold their previous values.
  - out_valid=0.
- Throughput: one operation per cycle; back-to-back in_valid is supported with no bubbles.
- No backpressure: the consumer must accept when out_valid=1.
- Boundary: all-ones + all-ones + 1 gives s = all-ones, cout=1. 0+0+0 gives s=0, cout=0. All-ones + 0 + 1 wraps s to 0 with cout=1.
- Reset mid-stream: an operation sampled in the same cycle as rst=1 is discarded; out_valid stays 0 the next cycle.
- Outputs are never X after the first reset edge.

Optional Feature:
- Macro: CORDIC_ADDER_OVF_EN.
- When defined:
  - Adds output port ovf (1 bit), the registered signed overflow = carry into bit N-1 XOR carry out of bit N-1.
  - ovf uses the same timing, hold and reset (0) rules as cout.
- When undefined: port ovf is absent and the logic is unchanged otherwise.

Decomposition:
- Shared package cordic_pkg holds:
  - CORDIC_W (default datapath width, 16), used as the default for N.
  - A localparam for the maximum supported width (64).
- One natural sub-module: full_adder, with inputs a, b, cin and outputs s, cout. It is purely combinational:
  - s = a^b^cin
  - cout = (a&b)|(cin&(a^b))
- The top instantiates N copies of full_adder in a generate loop plus the output register stage.

Test Plan:
- Reset: assert rst for 2 cycles with random inputs and in_valid=1 -> s=0, cout=0, out_valid=0 (ovf=0 when enabled).
- a=16'd0, b=16'd0, cin=0, in_valid=1 -> next cycle s=0, cout=0, out_valid=1.
- a=16'd20, b=16'd15, cin=0 then a=16'd10, b=16'd15, cin=1 back-to-back -> s=35, cout=0, then s=26, cout=0; out_valid high on both cycles.
- a=16'hFFFF, b=16'hFFFF, cin=1 -> s=16'hFFFF, cout=1. Then a=16'hFFFF, b=0, cin=1 -> s=0, cout=1.
- Hold and reset priority:
  - in_valid=0 for 3 cycles after a=7, b=8 -> s stays 15, out_valid=0.
  - rst=1 together with in_valid=1 -> s=0, out_valid=0.
- With CORDIC_ADDER_OVF_EN:
  - a=16'h7FFF, b=1, cin=0 -> s=16'h8000, cout=0, ovf=1.
  - a=16'h8000, b=16'h8000 -> s=0, cout=1, ovf=1.
  - Random comparison against {cout,s}=a+b+cin over 10k vectors at N=8, 16 and 32.
